// File: rtl/divider64.sv
// 64-bit restoring shift-subtract divider, one quotient bit per cycle.
// Optional signed support is enabled by defining DIVIDER64_SIGNED_EN (adds the sgn port).
module divider64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
`ifdef DIVIDER64_SIGNED_EN
    input  logic        sgn,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        dbz
);

    // state | meaning
    // IDLE  | waiting for start; results hold
    // RUN   | one shift-subtract iteration per cycle, cnt_q 63 -> 0
    // DONE  | one-cycle done pulse; results just updated
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] prem_q, prem_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic        op_signed;
    logic [63:0] dend_mag, dvs_mag;
    logic [64:0] shifted, trial;
    logic [63:0] iter_rem, iter_quo;
    logic [63:0] fin_quo, fin_rem;

`ifdef DIVIDER64_SIGNED_EN
    assign op_signed = sgn;
`else
    assign op_signed = 1'b0;
`endif

    // Signed operands are reduced to magnitudes at capture; signs are reapplied on DONE entry.
    assign dend_mag = (op_signed && dividend[63]) ? -dividend : dividend;
    assign dvs_mag  = (op_signed && divisor[63])  ? -divisor  : divisor;

    assign shifted  = {prem_q, acc_q[63]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign iter_rem = trial[64] ? shifted[63:0] : trial[63:0];
    assign iter_quo = {acc_q[62:0], ~trial[64]};

    assign fin_quo  = negq_q ? -iter_quo : iter_quo;
    assign fin_rem  = negr_q ? -iter_rem : iter_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d  = dvs_mag;
                    acc_d  = dend_mag;
                    prem_d = '0;
                    cnt_d  = 6'd63;
                    negq_d = op_signed & (dividend[63] ^ divisor[63]);
                    negr_d = op_signed & dividend[63];
                    if (divisor == 64'd0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                prem_d = iter_rem;
                acc_d  = iter_quo;
                cnt_d  = cnt_q - 6'd1;
                if (cnt_q == 6'd0) begin
                    state_d = DONE;
                    quo_d   = fin_quo;
                    rem_d   = fin_rem;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider64.sv
// Directed bench for divider64: vector table plus busy-start, reset-abort and signed sequences.
module tb_divider64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        sgn_r;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    divider64 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIVIDER64_SIGNED_EN
        .sgn       (sgn_r),
`endif
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] q;
        logic [63:0] r;
        logic        d;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one operation, scrambles the inputs right after acceptance, and checks
    // latency, busy, results, the single-cycle done and result hold.
    task automatic run_div(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic [63:0] eq, input logic [63:0] er,
                           input logic ed);
        int n;
        int lat_exp;
        logic busy_ok;
        lat_exp = (b == 64'd0) ? 0 : 64;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sgn_r    = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 64'h5;
        sgn_r    = ~s;
        chk({name, " busy_on_accept"}, {63'd0, busy}, 64'd1);
        n = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (done) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat_exp));
        chk({name, " busy_throughout"}, {63'd0, busy_ok}, 64'd1);
        chk({name, " quotient"}, quotient, eq);
        chk({name, " remainder"}, remainder, er);
        chk({name, " dbz"}, {63'd0, dbz}, {63'd0, ed});
        @(posedge clk);
        #1;
        chk({name, " done_one_cycle"}, {63'd0, done}, 64'd0);
        chk({name, " idle_busy"}, {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, " quotient_hold"}, quotient, eq);
        chk({name, " remainder_hold"}, remainder, er);
    endtask

    initial begin
        int ndone;
        logic [63:0] q_at_done;
        logic [63:0] r_at_done;

        vecs[0] = '{64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0};
        vecs[1] = '{64'd416, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd416, 1'b1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[3] = '{64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 64'd0, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd3, 1'b0, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0};
        vecs[6] = '{64'd123456789, 64'd1000, 1'b0, 64'd123456, 64'd789, 1'b0};
        vecs[7] = '{64'd0, 64'd5, 1'b0, 64'd0, 64'd0, 1'b0};
        vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        sgn_r    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset dbz", {63'd0, dbz}, 64'd0);
        chk("reset quotient", quotient, 64'd0);
        chk("reset remainder", remainder, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                    vecs[i].q, vecs[i].r, vecs[i].d);
        end

        // A start during RUN (with a zero divisor that would finish fast) must be dropped.
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dividend = 64'd50;
        divisor  = 64'd0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ndone     = 0;
        q_at_done = '0;
        r_at_done = '0;
        for (int c = 0; c < 90; c++) begin
            if (done) begin
                ndone++;
                q_at_done = quotient;
                r_at_done = remainder;
            end
            @(posedge clk);
            #1;
        end
        chk("busy_start done_count", 64'(ndone), 64'd1);
        chk("busy_start quotient", q_at_done, 64'd14);
        chk("busy_start remainder", r_at_done, 64'd2);
        chk("busy_start no_overwrite", quotient, 64'd14);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midreset busy", {63'd0, busy}, 64'd0);
        chk("midreset done", {63'd0, done}, 64'd0);
        chk("midreset dbz", {63'd0, dbz}, 64'd0);
        chk("midreset quotient", quotient, 64'd0);
        chk("midreset remainder", remainder, 64'd0);
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            if (c == 3) begin
                @(negedge clk);
                reset = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midreset no_done", 64'(ndone), 64'd0);
        run_div("after_reset", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);

`ifdef DIVIDER64_SIGNED_EN
        run_div("s_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_div("s_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
        run_div("s_min_m1", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'h8000_0000_0000_0000, 64'd0, 1'b0);
        run_div("s_m7_0", 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        run_div("u_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0,
                64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider64.md
DIVIDER64 -- requirements
Module: divider64

Interface
REQ-001 The block SHALL have these ports, one per line, in order: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a division; sampled only when busy=0.
- dividend  input  64  numerator; captured on the accepting edge.
- divisor  input  64  denominator; captured on the accepting edge.
- sgn  input  1  signed-operation select; present only when DIVIDER64_SIGNED_EN is defined.
- busy  output  1  high while a division is in progress (states RUN and DONE).
- done  output  1  one-cycle pulse; results are valid.
- quotient  output  64  result quotient.
- remainder  output  64  result remainder.
- dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-002 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-003 In IDLE with start=1, the rising edge SHALL capture dividend, divisor (and sgn) and go to RUN; if the captured divisor is 0, it SHALL go directly to DONE instead.
REQ-004 RUN SHALL perform one restoring shift-subtract iteration per cycle, 64 iterations total.
REQ-005 The iteration counter SHALL be 6 bits, start at 63, and decrement; RUN->DONE SHALL occur on the edge that completes iteration 0.
REQ-006 Each iteration SHALL be a 65-bit trial subtraction of the divisor from the shifted partial remainder; a non-negative result SHALL be kept and its quotient bit set to 1, otherwise the partial remainder SHALL be restored and the quotient bit set to 0.
REQ-007 Latency: with a nonzero divisor, done SHALL be high in the cycle following the 64th edge after the accepting edge.
REQ-008 Latency: with a zero divisor, done SHALL be high in the cycle immediately after the accepting edge.
REQ-009 DONE SHALL last exactly one cycle, with done=1, and SHALL then return to IDLE unconditionally.
REQ-010 quotient, remainder and dbz SHALL update only on entry to DONE and SHALL hold their values until the next DONE entry.
REQ-011 On a divisor of 0, the results SHALL be quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=the captured dividend, dbz=1.
REQ-012 On a nonzero divisor, the result SHALL have dbz=0.
REQ-013 A start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-014 Input changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-015 busy SHALL be 0 only in IDLE; start accepted in IDLE SHALL raise busy on the same edge.

Reset
REQ-016 reset=0 SHALL immediately, regardless of clk, force IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, and clear all internal registers.
REQ-017 A reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-018 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-019 Defining the macro DIVIDER64_SIGNED_EN SHALL add the sgn port and signed support.
REQ-020 With DIVIDER64_SIGNED_EN defined and sgn=1:
- operands are two's complement;
- magnitudes are divided as unsigned;
- the quotient is negated when the operand signs differ (truncation toward zero);
- the remainder takes the sign of the dividend;
- the fixup is applied on the DONE-entry edge, with no added latency;
- 64'h8000_0000_0000_0000 / -1 SHALL give quotient=64'h8000_0000_0000_0000 and remainder=0;
- divide-by-zero results SHALL be as in REQ-011.
REQ-021 Without DIVIDER64_SIGNED_EN, the sgn port SHALL be absent and all operations SHALL be unsigned.

Verification
REQ-022 Basic divide: dividend=100, divisor=7, start for one cycle -> done 64 cycles after acceptance, quotient=14, remainder=2, dbz=0, busy high throughout.
REQ-023 Divide by zero: dividend=416, divisor=0 -> done in the next cycle, quotient=all ones, remainder=416, dbz=1.
REQ-024 Extremes: dividend=64'hFFFF_FFFF_FFFF_FFFF, divisor=1 -> quotient=all ones, remainder=0.
REQ-025 Extremes: dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-026 Start while busy: start pulsed at cycle 10 of RUN with different operands -> the original result completes and exactly one done pulse occurs.
REQ-027 Reset mid-run: reset low at cycle 30 of RUN -> all outputs go to 0 at once, no done pulse; a new start after release yields a correct result.
REQ-028 Signed (macro defined): sgn=1, -7/2 -> quotient=-3, remainder=-1; 7/-2 -> quotient=-3, remainder=1.
